// File: rtl/ram_port_arbiter.sv
// Sequencer for a single-port RAM: clears the array after reset, then arbitrates
// two clients round-robin and steers registered read data back to the issuer.
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  init_done
);

    typedef enum logic {
        INIT,
        ARB
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  last_grant;
    logic                  rd_pending;
    logic                  rd_owner;
    logic                  grant0;
    logic                  grant1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= INIT;
            init_cnt   <= '0;
            last_grant <= 1'b1;
            rd_pending <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
            if (grant0 || grant1) begin
                last_grant <= grant1;
                rd_owner   <= grant1;
            end
            rd_pending <= (grant0 && !req0_we) || (grant1 && !req1_we);
        end
    end

    // Every output is forced idle while rst is high, even before the state register settles.
    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_data   = '0;
        init_done  = 1'b0;
        if (!rst) begin
            case (state)
                INIT: begin
                    ram_we   = 1'b1;
                    ram_addr = init_cnt;
                    if (init_cnt == '1) begin
                        state_next = ARB;
                    end
                end
                ARB: begin
                    init_done = 1'b1;
                    // On conflict, the client not granted last time wins.
                    grant0 = req0_valid && (!req1_valid || last_grant);
                    grant1 = req1_valid && (!req0_valid || !last_grant);
                    if (grant0) begin
                        ram_we   = req0_we;
                        ram_addr = req0_addr;
                        ram_data = req0_wdata;
                    end else if (grant1) begin
                        ram_we   = req1_we;
                        ram_addr = req1_addr;
                        ram_data = req1_wdata;
                    end
                end
                default: state_next = INIT;
            endcase
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign rsp0_valid = !rst && rd_pending && !rd_owner;
    assign rsp1_valid = !rst && rd_pending && rd_owner;
    assign rsp0_rdata = rsp0_valid ? ram_q : '0;
    assign rsp1_rdata = rsp1_valid ? ram_q : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomised and directed bench for ram_port_arbiter with a bench-side RAM and a
// transaction-level expectation model checked every cycle.
module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req0_we = 1'b0;
    logic [5:0] req0_addr = '0;
    logic [7:0] req0_wdata = '0;
    logic       req0_ready, rsp0_valid;
    logic [7:0] rsp0_rdata;
    logic       req1_valid = 1'b0, req1_we = 1'b0;
    logic [5:0] req1_addr = '0;
    logic [7:0] req1_wdata = '0;
    logic       req1_ready, rsp1_valid;
    logic [7:0] rsp1_rdata;
    logic [7:0] ram_data;
    logic [5:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_q;
    logic       init_done;

    ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_q(ram_q), .init_done(init_done)
    );

    always #5 clk = ~clk;

    // Bench-side 64x8 RAM with registered address
    logic [7:0] mem [64];
    logic [5:0] addr_q = '0;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        addr_q <= ram_addr;
    end
    assign ram_q = mem[addr_q];

    int unsigned cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Expectation model state
    bit         armed = 0;
    int         since_rst = 0;
    bit         last_winner = 1;
    logic [7:0] shadow [64];
    bit         pend_v = 0, pend_o = 0;
    logic [7:0] pend_d = '0;

    typedef struct { int unsigned cyc; int who; } grant_t;
    typedef struct { int unsigned cyc; logic [7:0] d; } rsp_t;
    grant_t grant_log[$];
    rsp_t   rsp0_log[$];
    rsp_t   rsp1_log[$];

    bit         eg0, eg1, ev0, ev1, ewe, edone;
    logic [5:0] ea;
    logic [7:0] ed, er0, er1;

    always @(negedge clk) begin
        if (rst) begin
            armed = 1;
            check("rst_ready0", req0_ready, 0);
            check("rst_ready1", req1_ready, 0);
            check("rst_rsp0_valid", rsp0_valid, 0);
            check("rst_rsp1_valid", rsp1_valid, 0);
            check("rst_rsp0_rdata", rsp0_rdata, 0);
            check("rst_rsp1_rdata", rsp1_rdata, 0);
            check("rst_init_done", init_done, 0);
            check("rst_ram_we", ram_we, 0);
            since_rst = 0;
            last_winner = 1;
            pend_v = 0;
        end else if (armed) begin
            ev0 = pend_v && !pend_o;
            ev1 = pend_v && pend_o;
            er0 = ev0 ? pend_d : 8'h00;
            er1 = ev1 ? pend_d : 8'h00;
            if (since_rst < 64) begin
                eg0 = 0; eg1 = 0; edone = 0;
                ewe = 1; ea = since_rst[5:0]; ed = 8'h00;
            end else begin
                edone = 1;
                eg0 = req0_valid && (!req1_valid || last_winner);
                eg1 = req1_valid && !eg0;
                ewe = 0; ea = '0; ed = '0;
                if (eg0) begin ewe = req0_we; ea = req0_addr; ed = req0_wdata; end
                if (eg1) begin ewe = req1_we; ea = req1_addr; ed = req1_wdata; end
            end
            check("ready0", req0_ready, eg0);
            check("ready1", req1_ready, eg1);
            check("init_done", init_done, edone);
            check("ram_we", ram_we, ewe);
            check("ram_addr", ram_addr, ea);
            check("ram_data", ram_data, ed);
            check("rsp0_valid", rsp0_valid, ev0);
            check("rsp1_valid", rsp1_valid, ev1);
            check("rsp0_rdata", rsp0_rdata, er0);
            check("rsp1_rdata", rsp1_rdata, er1);

            if (req0_valid && req0_ready) grant_log.push_back('{cycle, 0});
            if (req1_valid && req1_ready) grant_log.push_back('{cycle, 1});
            if (rsp0_valid) rsp0_log.push_back('{cycle, rsp0_rdata});
            if (rsp1_valid) rsp1_log.push_back('{cycle, rsp1_rdata});

            pend_v = 0;
            if (ewe) begin
                shadow[ea] = ed;
            end else if (eg0 || eg1) begin
                pend_v = 1;
                pend_o = eg1;
                pend_d = shadow[ea];
            end
            if (eg0 || eg1) last_winner = eg1;
            since_rst++;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int c, input logic we, input logic [5:0] a, input logic [7:0] d);
        int n = 0;
        bit ok = 0;
        if (c == 0) begin
            req0_we = we; req0_addr = a; req0_wdata = d; req0_valid = 1'b1;
        end else begin
            req1_we = we; req1_addr = a; req1_wdata = d; req1_valid = 1'b1;
        end
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = (c == 0) ? req0_ready : req1_ready;
            n++;
        end
        if (!ok) check("ready_timeout", 0, 1);
        sync();
        if (c == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic do_reset(output int unsigned fall);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        fall = cycle;
    endtask

    task automatic idle(input int k);
        repeat (k) sync();
    endtask

    initial begin
        int unsigned fall;
        int n0, n1, g0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 8'($urandom);
            shadow[i] = 8'hxx;
        end
        #1;
        do_reset(fall);

        // Init sweep pinned with literal addresses
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (i == 0 || i == 5 || i == 63) begin
                check("init_addr_lit", ram_addr, i);
                check("init_we_lit", ram_we, 1);
            end
        end
        @(negedge clk);
        check("init_done_at_64", init_done, 1);
        sync();
        n0 = rsp0_log.size();
        issue(0, 1'b0, 6'd5, 8'h00);
        idle(2);
        check("init_read5_count", rsp0_log.size(), n0 + 1);
        if (rsp0_log.size() > n0) check("init_read5_data", rsp0_log[n0].d, 8'h00);

        // Single client write/read
        n0 = rsp0_log.size();
        n1 = rsp1_log.size();
        for (int i = 0; i < 3; i++) issue(0, 1'b1, 6'(i), 8'(i + 1));
        for (int i = 0; i < 3; i++) issue(0, 1'b0, 6'(i), 8'h00);
        idle(2);
        check("single_rsp_count", rsp0_log.size(), n0 + 3);
        for (int i = 0; i < 3; i++)
            if (rsp0_log.size() > n0 + i) check("single_rsp_data", rsp0_log[n0 + i].d, i + 1);
        if (rsp0_log.size() >= n0 + 3)
            check("single_rsp_spacing", rsp0_log[n0 + 2].cyc - rsp0_log[n0].cyc, 2);
        check("single_no_rsp1", rsp1_log.size(), n1);

        // Continuous contention from cycle 64, requests held through INIT
        do_reset(fall);
        grant_log.delete();
        fork
            for (int i = 0; i < 6; i++) issue(0, 1'(i & 1), 6'(10 + i), 8'(8'h20 + i));
            for (int i = 0; i < 6; i++) issue(1, 1'(i & 1), 6'(20 + i), 8'(8'h30 + i));
        join
        check("cont_grant_count", grant_log.size(), 12);
        if (grant_log.size() > 0) check("cont_first_cycle", grant_log[0].cyc - fall, 64);
        for (int i = 0; i < grant_log.size() && i < 12; i++)
            check("cont_alternate", grant_log[i].who, i % 2);

        // Read-after-write across a conflict
        idle(1);
        g0 = grant_log.size();
        n1 = rsp1_log.size();
        fork
            issue(0, 1'b1, 6'd1, 8'h04);
            issue(1, 1'b0, 6'd1, 8'h00);
        join
        idle(2);
        if (grant_log.size() >= g0 + 2) begin
            check("raw_first_winner", grant_log[g0].who, 0);
            check("raw_second_gap", grant_log[g0 + 1].cyc - grant_log[g0].cyc, 1);
        end else check("raw_grants", grant_log.size(), g0 + 2);
        if (rsp1_log.size() > n1) check("raw_rdata", rsp1_log[n1].d, 8'h04);
        else check("raw_rsp_count", rsp1_log.size(), n1 + 1);

        // Reset in the cycle after a read grant
        n0 = rsp0_log.size();
        issue(0, 1'b0, 6'd1, 8'h00);
        do_reset(fall);
        check("midrst_no_rsp", rsp0_log.size(), n0);
        @(negedge clk);
        check("midrst_init_addr0", ram_addr, 0);
        check("midrst_init_we", ram_we, 1);
        sync();
        g0 = grant_log.size();
        fork
            issue(0, 1'b1, 6'd7, 8'h55);
            issue(1, 1'b1, 6'd8, 8'h66);
        join
        if (grant_log.size() > g0) check("midrst_first_winner", grant_log[g0].who, 0);
        else check("midrst_grants", grant_log.size(), g0 + 1);

        // Streaming reads from client 1
        for (int i = 0; i < 64; i++) issue(1, 1'b1, 6'(i), 8'(i + 1));
        n1 = rsp1_log.size();
        for (int i = 0; i < 64; i++) issue(1, 1'b0, 6'(i), 8'h00);
        idle(2);
        check("stream_count", rsp1_log.size(), n1 + 64);
        if (rsp1_log.size() >= n1 + 64) begin
            for (int i = 0; i < 64; i++) begin
                if (rsp1_log[n1 + i].d !== 8'(i + 1)) check("stream_data", rsp1_log[n1 + i].d, i + 1);
            end
            check("stream_first", rsp1_log[n1].d, 8'h01);
            check("stream_last", rsp1_log[n1 + 63].d, 8'h40);
            check("stream_span", rsp1_log[n1 + 63].cyc - rsp1_log[n1].cyc, 63);
        end

        // Random traffic from both clients
        fork
            for (int i = 0; i < 150; i++) begin
                idle($urandom_range(0, 2));
                issue(0, 1'($urandom), 6'($urandom), 8'($urandom));
            end
            for (int i = 0; i < 150; i++) begin
                idle($urandom_range(0, 2));
                issue(1, 1'($urandom), 6'($urandom), 8'($urandom));
            end
        join
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter and sequencer for the 64 x 8 single-port RAM (`data`/`addr`/`we`/`clk`/`q`). It zero-initialises the whole RAM after reset, then gives the single port to two clients with round-robin priority. It also returns read data to the client that issued the read. It sits between the RAM and its clients, and it is the only block that drives the RAM port.

## Interface
- `DATA_WIDTH`, 8: RAM word width.
- `ADDR_WIDTH`, 6: RAM address width. Depth is 2^ADDR_WIDTH = 64.

Ports:
- `clk`  in  1  clock; all logic uses the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  client 0 has a request.
- `req0_we`  in  1  1 = write, 0 = read.
- `req0_addr`  in  ADDR_WIDTH  request address.
- `req0_wdata`  in  DATA_WIDTH  write data.
- `req0_ready`  out  1  request accepted this cycle.
- `rsp0_valid`  out  1  read data valid for client 0.
- `rsp0_rdata`  out  DATA_WIDTH  read data for client 0.
- `req1_*`, `rsp1_*`  same signals as client 0, for client 1.
- `ram_data`  out  DATA_WIDTH  drives RAM `data`.
- `ram_addr`  out  ADDR_WIDTH  drives RAM `addr`.
- `ram_we`  out  1  drives RAM `we`.
- `ram_q`  in  DATA_WIDTH  from RAM `q`.
- `init_done`  out  1  high once the RAM clear is complete.

## Operation
- RAM model: on the rising edge, a write stores `data` at `addr` when `we`=1. The address is registered, so `q` shows the word at the sampled address in the following cycle.
- Handshake: a transfer occurs in a cycle where `reqN_valid` and `reqN_ready` are both 1.
  - Once a client raises valid, it must hold valid, we, addr and wdata stable until ready.
  - `reqN_ready` is combinational from the valid inputs and the state.
- FSM states:
  - INIT:
    - `ram_we`=1, `ram_addr`=init counter, `ram_data`=0.
    - Both readies are 0.
    - The counter increments each cycle, 0..63.
    - After addr 63 the FSM moves to ARB.
  - ARB:
    - `init_done`=1.
    - At most one grant per cycle.
    - Only one client valid: that client is granted.
    - Both clients valid: grant the client that was not granted last. `last_grant` updates on every grant.
    - Granted client: its fields drive `ram_addr`/`ram_data`, and `ram_we`=`reqN_we`.
    - No grant: `ram_we`=0, `ram_addr`=0, `ram_data`=0.
- Read return path:
  - A granted read sets the `rd_pending` register and records the owner in `rd_owner`.
  - In the next cycle, `rspX_valid`=1 for exactly one cycle, with `rspX_rdata`=`ram_q`.
  - A non-owner's `rsp_rdata` is 0.
- Writes produce no response.

## Timing
- While `rst`=1, and at the first edge after:
  - state=INIT, init counter=0, `last_grant`=1 (client 0 wins the first conflict), `rd_pending`=0.
  - Both readies, both `rsp_valid`, both `rsp_rdata` and `init_done` are 0.
  - `ram_we`=0 while `rst` is high.
- Cycles 0..63 after `rst` falls: INIT writes addresses 0..63.
- Cycle 64: `init_done`=1 and the first grant is possible.
- Read latency: grant in cycle N gives `rsp_valid` in cycle N+1. Back-to-back reads give one response per cycle, in grant order.
- Write at cycle N followed by a read of the same address at N+1 or later returns the new data.
- Contention: the loser keeps valid high and is granted in the next cycle.
  - Under continuous contention, grants strictly alternate.
  - Maximum wait is 1 cycle.
- Addresses are exactly ADDR_WIDTH bits, so there is no wrap logic. Address 63 is a normal address.
- Reset mid-operation:
  - Any pending response is dropped; `rsp_valid` stays 0.
  - INIT restarts at address 0.
  - The round-robin pointer returns to its reset value.
- Requests presented during INIT are not lost: ready stays 0 and they are served from cycle 64.

## Test plan
- Reset/init: `rst` high 2 cycles, then low.
  - `ram_we`=1 for exactly 64 consecutive cycles with `ram_addr` 0..63 and `ram_data`=0x00.
  - `init_done` rises at cycle 64.
  - A client-0 read of addr 5 returns 0x00.
- Single client: client 0 writes 0x01@0, 0x02@1, 0x03@2, then reads 0, 1, 2.
  - `rsp0_valid` pulses one cycle after each read grant, with data 0x01, 0x02, 0x03.
  - `rsp1_valid` never asserts.
- Contention: both clients valid continuously from cycle 64.
  - Grant order is 0, 1, 0, 1, …
  - Each `rsp` goes only to the read's issuer.
- Read-after-write: in the same cycle, client 0 writes 0x04@1 and client 1 reads @1.
  - Client 0 is granted at N and client 1 at N+1.
  - `rsp1_rdata`=0x04 at N+2.
- Reset mid-read: `rst` asserted in the cycle after a read grant.
  - No `rsp_valid`.
  - INIT restarts at addr 0.
  - After re-init, the first conflict is won by client 0.
- Streaming: client 1 reads addr 0..63 back-to-back after writing data = addr+1.
  - 64 consecutive responses 0x01..0x40 in order, one per cycle.
